// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/half/word accesses to a single-cycle data memory.
// Ports: req_* request handshake; resp_* response pulse; d* memory port (drdata combinational).
// Latency: legal request responds 2 edges after accept, errored request 1 edge; one request at a time.
module load_store_unit #(
  parameter int DMEM_SIZE = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:2] daddr,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  output logic        dce,
  output logic [3:0]  dwstb
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        dce_q;
  logic [3:0]  dwstb_q;

  logic        code_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_bad;
  logic [3:0]  stb_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode, evaluated on the live request inputs at accept time.
  always_comb begin
    if (req_we) begin
      code_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      code_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DMEM_SIZE));
    req_bad      = !code_ok || misaligned || out_of_range;

    case (req_funct3[1:0])
      2'b00: begin
        stb_c   = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        stb_c   = 4'b0011 << req_addr[1:0];
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        stb_c   = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  // Load lane select and extension from the memory word during MEM.
  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = drdata[7:0];
      2'd1:    ld_byte = drdata[15:8];
      2'd2:    ld_byte = drdata[23:16];
      default: ld_byte = drdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? drdata[31:16] : drdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = drdata;
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      dce_q      <= 1'b0;
      dwstb_q    <= 4'b0000;
      daddr      <= '0;
      dwdata     <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            if (req_bad) begin
              // Errored requests skip the memory entirely.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state   <= MEM;
              dce_q   <= 1'b1;
              daddr   <= req_addr[31:2];
              dwstb_q <= req_we ? stb_c : 4'b0000;
              if (req_we) begin
                dwdata <= wdata_c;
              end
            end
          end
        end
        MEM: begin
          state      <= RESP;
          dce_q      <= 1'b0;
          dwstb_q    <= 4'b0000;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= we_q ? 32'h0 : ld_ext;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  // Reset must suppress the write on the very edge it is sampled, so the
  // registered enables are masked combinationally while it is asserted.
  assign dce   = dce_q & ~rst;
  assign dwstb = dwstb_q & {4{~rst}};

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DMEM_SIZE SHALL default to 32768 and give the data-memory depth in 32-bit words.
REQ-002 CLK input 1 SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST input 1 SHALL be the synchronous, active-high reset.
REQ-004 REQ_VALID input 1 SHALL request a memory operation.
REQ-005 REQ_READY output 1 SHALL indicate the unit can accept a request this cycle.
REQ-006 REQ_WE input 1 SHALL select store (1) or load (0).
REQ-007 REQ_FUNCT3 input 3 SHALL carry the RV32I width/sign code.
REQ-008 REQ_ADDR input 32 SHALL carry the byte address.
REQ-009 REQ_WDATA input 32 SHALL carry store data, right-aligned.
REQ-010 RESP_VALID output 1 SHALL pulse for one cycle per completed request.
REQ-011 RESP_RDATA output 32 SHALL carry the extended load result.
REQ-012 RESP_ERR output 1 SHALL flag a misaligned, illegal or out-of-range request, qualified by RESP_VALID.
REQ-013 DADDR output [31:2] SHALL drive the memory word address.
REQ-014 DWDATA output 32 SHALL drive byte-lane-replicated store data.
REQ-015 DRDATA input 32 SHALL receive the combinational memory read word.
REQ-016 DCE output 1 SHALL drive the memory enable.
REQ-017 DWSTB output 4 SHALL drive the per-byte write strobes; bit n enables bits 8n+7:8n.

Function
REQ-018 The FSM SHALL have states IDLE, MEM and RESP; REQ_READY SHALL be 1 only in IDLE.
REQ-019 Handshake: in IDLE with REQ_VALID=1, the unit SHALL register WE, FUNCT3, ADDR and WDATA; it SHALL ignore REQ_* in MEM and RESP.
REQ-020 Legal codes: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-021 Misaligned: halfword with ADDR[0]=1; word with ADDR[1:0]!=0.
REQ-022 Out of range: ADDR[31:2] >= DMEM_SIZE.
REQ-023 An accepted request that is illegal, misaligned or out of range SHALL go IDLE->RESP with RESP_ERR=1, RESP_RDATA=0, and no DCE or DWSTB assertion.
REQ-024 A legal request SHALL go IDLE->MEM->RESP->IDLE; RESP_VALID SHALL be 1 exactly two cycles after the accept edge.
REQ-025 In MEM: DCE=1 and DADDR=latched ADDR[31:2].
REQ-026 Store strobes in MEM: SB 0001<<ADDR[1:0]; SH 0011<<ADDR[1:0]; SW 1111.
REQ-027 Store data: SB replicates WDATA[7:0] to all four lanes; SH replicates WDATA[15:0] to both halves; SW passes WDATA through.
REQ-028 For a load in MEM: DWSTB=0; the unit SHALL select the byte or halfword from DRDATA by ADDR[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), and register the result into RESP_RDATA at the end of MEM.
REQ-029 Outside MEM: DCE=0 and DWSTB=0; DADDR and DWDATA hold their last values.
REQ-030 RESP_RDATA SHALL be 0 on store responses and SHALL hold its value until the next response.
REQ-031 A new request SHALL be acceptable in the cycle after RESP, giving a minimum issue interval of 3 cycles for legal requests and 2 cycles for errored requests.

Reset
REQ-032 RST=1 at a clock edge SHALL force IDLE and clear RESP_VALID, RESP_ERR, RESP_RDATA, DCE, DWSTB, DADDR and DWDATA to 0.
REQ-033 Reset asserted in MEM SHALL abort the request: no write at that edge and no response afterwards.
REQ-034 REQ_READY SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 SW addr 0x10, wdata 0xDEADBEEF -> MEM cycle: DWSTB=1111, DADDR=4, DCE=1; RESP_VALID two cycles after accept, RESP_ERR=0.
REQ-036 Word at 0x10 = 0x80FF7F01: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01.
REQ-037 SB addr 0x21, wdata 0x000000AB -> DWSTB=0010, DWDATA=0xABABABAB; a following LW 0x20 returns the updated byte 1 only.
REQ-038 LW 0x22, SH 0x11, funct3 011, and ADDR=DMEM_SIZE*4 -> each gives RESP_VALID with RESP_ERR=1 one cycle after accept, DCE never asserted.
REQ-039 RST pulsed during the MEM cycle of an SW -> memory word unchanged, no RESP_VALID, REQ_READY=1 after reset.
REQ-040 REQ_VALID held high for 9 cycles with legal loads -> exactly 3 accepts and 3 RESP_VALID pulses.
